multi_cycle_ctrl: RTL and testbench
===================================

// Module: multi_cycle_ctrl
// PURPOSE
//  Moore/Mealy FSM sequencing the multi-cycle MIPS datapath: drives the enables of the PC, IR, MDR and register-file
//  registers, the memory strobes and the mux/ALU selects.
//  Sits between the IR opcode field and the datapath; stalls on a memory-ready handshake.
// PARAMETERS
//  MEM_HANDSHAKE  1  1: memory states wait for mem_ready; 0: mem_ready ignored (single-cycle memory)
// PORTS
//  clk            in   1  clock, all state updates on rising edge
//  rst            in   1  synchronous reset, active-high
//  opcode         in   6  IR[31:26], sampled in ID
//  mem_ready      in   1  memory access completes this cycle
//  pc_write       out  1  unconditional PC enable
//  pc_write_cond  out  1  PC enable qualified by ALU zero (beq)
//  branch_ne      out  1  invert zero qualification (bne)
//  ir_write       out  1  IR enable
//  mem_read       out  1  memory read strobe
//  mem_write      out  1  memory write strobe
//  i_or_d         out  1  0: address=PC, 1: address=ALUOut
//  reg_write      out  1  register-file write enable
//  reg_dst        out  1  1: rd, 0: rt
//  mem_to_reg     out  1  1: MDR, 0: ALUOut
//  alu_src_a      out  1  0: PC, 1: A
//  alu_src_b      out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op         out  2  00 add, 01 sub, 10 use funct
//  pc_source      out  2  00 ALU, 01 ALUOut, 10 jump target
//  illegal_op     out  1  one-cycle pulse: unsupported opcode decoded in ID
//  state          out  4  current state, for debug
// BEHAVIOUR
//  - States (encoding): IF=0 ID=1 MEM_ADR=2 MEM_RD=3 MEM_WB=4 MEM_WR=5 R_EX=6 R_WB=7 BEQ=8 J=9 ADDI_EX=10
//    ADDI_WB=11 (BNE=12 with macro). Unused encodings -> IF next cycle, all outputs 0.
//  - rst high at edge: state<=IF. While rst is high, all enables/strobes/illegal_op are forced 0 (combinationally);
//    selects are 0. Reset mid-instruction aborts it; no partial write issued in the reset cycle.
//  - Outputs decode from state (Moore) except ir_write/pc_write in IF (qualified by ready); unlisted outputs are 0.
//  - "ready" = mem_ready if MEM_HANDSHAKE=1, else 1.
//  - IF: mem_read=1, i_or_d=0, a=0, b=01, op=00, psrc=00; ir_write=pc_write=ready; ready ? ID : IF.
//  - ID: a=0, b=11, op=00. Opcode dispatch: 000000->R_EX, 100011/101011->MEM_ADR, 000100->BEQ, 000010->J,
//    001000->ADDI_EX; any other -> IF with illegal_op=1 in this ID cycle.
//  - MEM_ADR: a=1, b=10, op=00; lw->MEM_RD, sw->MEM_WR (opcode held stable by IR).
//  - MEM_RD: mem_read=1, i_or_d=1; ready ? MEM_WB : MEM_RD.  MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> IF.
//  - MEM_WR: mem_write=1, i_or_d=1; ready ? IF : MEM_WR (strobe held every stall cycle).
//  - R_EX: a=1, b=00, op=10 -> R_WB.  R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> IF.
//  - BEQ: a=1, b=00, op=01, psrc=01, pc_write_cond=1 -> IF.  J: pc_write=1, psrc=10 -> IF.
//  - ADDI_EX: a=1, b=10, op=00 -> ADDI_WB.  ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> IF.
//  - Latency with ready=1: lw 5, sw 4, R/addi 4, beq/j 3 cycles; each stall cycle adds 1.
// CONFIGURATION
//  MULTI_CYCLE_CTRL_BNE_EN defined: opcode 000101 in ID -> BNE; BNE drives BEQ outputs plus branch_ne=1 -> IF.
//  Not defined: branch_ne tied 0; 000101 is illegal (illegal_op pulse, ID->IF); encoding 12 unused.
// TESTING
//  rst=1 two cycles then lw(100011), mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 only in state 4, mem_to_reg=1.
//  R-type 000000 -> 0,1,6,7,0; alu_op=10 in 6; reg_dst=1, reg_write=1 in 7; beq 000100 -> 0,1,8,0, pc_write_cond=1 in 8.
//  mem_ready=0 for 2 cycles in IF -> IF held 3 cycles, mem_read=1 throughout, ir_write/pc_write=1 only in 3rd.
//  sw with rst asserted during MEM_WR -> mem_write=0 that cycle, state=0 next cycle, no further write.
//  opcode 111111 -> 0,1,0 with illegal_op=1 exactly in state-1 cycle; no reg_write/mem_write issued.
//  opcode 000101: macro on -> 0,1,12,0 with branch_ne=1, pc_write_cond=1; macro off -> illegal_op pulse, 0,1,0.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: control FSM for the multi-cycle MIPS datapath.
// Sequences instruction fetch, decode and the per-class execute/memory/write-back
// states, stalling on mem_ready during memory states when MEM_HANDSHAKE is set.
// Optional feature: define MULTI_CYCLE_CTRL_BNE_EN to add the BNE state (encoding 12).
module multi_cycle_ctrl #(
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EX    = 4'd6,
    S_R_WB    = 4'd7,
    S_BEQ     = 4'd8,
    S_J       = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_BNE     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state_r;
  state_t next_state_s;
  logic   ready_s;

  // With single-cycle memory the handshake is ignored and every access completes at once.
  assign ready_s = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign state   = state_r;

  // State register with synchronous reset back to fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IF;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode; reset forces every output low so an aborted
  // instruction cannot issue a partial write in the reset cycle.
  always_comb begin
    next_state_s  = S_IF;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    if (rst) begin
      next_state_s = S_IF;
    end else begin
      case (state_r)
        S_IF: begin
          mem_read     = 1'b1;
          alu_src_b    = 2'b01;
          ir_write     = ready_s;
          pc_write     = ready_s;
          next_state_s = ready_s ? S_ID : S_IF;
        end
        S_ID: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_RTYPE: next_state_s = S_R_EX;
            OP_LW:    next_state_s = S_MEM_ADR;
            OP_SW:    next_state_s = S_MEM_ADR;
            OP_BEQ:   next_state_s = S_BEQ;
            OP_J:     next_state_s = S_J;
            OP_ADDI:  next_state_s = S_ADDI_EX;
`ifdef MULTI_CYCLE_CTRL_BNE_EN
            OP_BNE:   next_state_s = S_BNE;
`endif
            default: begin
              illegal_op   = 1'b1;
              next_state_s = S_IF;
            end
          endcase
        end
        S_MEM_ADR: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b10;
          next_state_s = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_read     = 1'b1;
          i_or_d       = 1'b1;
          next_state_s = ready_s ? S_MEM_WB : S_MEM_RD;
        end
        S_MEM_WB: begin
          reg_write    = 1'b1;
          mem_to_reg   = 1'b1;
          next_state_s = S_IF;
        end
        S_MEM_WR: begin
          mem_write    = 1'b1;
          i_or_d       = 1'b1;
          next_state_s = ready_s ? S_IF : S_MEM_WR;
        end
        S_R_EX: begin
          alu_src_a    = 1'b1;
          alu_op       = 2'b10;
          next_state_s = S_R_WB;
        end
        S_R_WB: begin
          reg_write    = 1'b1;
          reg_dst      = 1'b1;
          next_state_s = S_IF;
        end
        S_BEQ: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_source     = 2'b01;
          pc_write_cond = 1'b1;
          next_state_s  = S_IF;
        end
`ifdef MULTI_CYCLE_CTRL_BNE_EN
        S_BNE: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_source     = 2'b01;
          pc_write_cond = 1'b1;
          branch_ne     = 1'b1;
          next_state_s  = S_IF;
        end
`endif
        S_J: begin
          pc_write     = 1'b1;
          pc_source    = 2'b10;
          next_state_s = S_IF;
        end
        S_ADDI_EX: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b10;
          next_state_s = S_ADDI_WB;
        end
        S_ADDI_WB: begin
          reg_write    = 1'b1;
          next_state_s = S_IF;
        end
        default: begin
          next_state_s = S_IF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed testbench for multi_cycle_ctrl: walks each instruction class through
// its state sequence and checks state and key control outputs every cycle.
module tb_multi_cycle_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, ir_write, mem_read, mem_write;
  logic       i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  multi_cycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Two reset cycles: state settles to IF and every enable is held low.
  task automatic test_reset();
    rst = 1'b1; opcode = 6'b100011; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    tests++; if (state !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
    tests++; if (mem_read !== 1'b0) begin fails++; $display("FAIL reset_mem_read: got %b expected 0", mem_read); end
    tests++; if ({ir_write, pc_write, reg_write, mem_write, illegal_op} !== 5'b00000) begin
      fails++; $display("FAIL reset_enables: got %b expected 00000", {ir_write, pc_write, reg_write, mem_write, illegal_op}); end
    tests++; if (alu_src_b !== 2'b00) begin fails++; $display("FAIL reset_alu_src_b: got %b expected 00", alu_src_b); end
    rst = 1'b0; #1;
    tests++; if ({mem_read, ir_write, pc_write, alu_src_b} !== 5'b11101) begin
      fails++; $display("FAIL if_after_reset: got %b expected 11101", {mem_read, ir_write, pc_write, alu_src_b}); end
  endtask

  // lw: 0,1,2,3,4,0 with register write from MDR only in state 4.
  task automatic test_lw();
    logic [3:0] es [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic       ew [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       er [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    opcode = 6'b100011; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests++; if (state !== es[i]) begin fails++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      tests++; if (reg_write !== ew[i]) begin fails++; $display("FAIL lw_reg_write[%0d]: got %b expected %b", i, reg_write, ew[i]); end
      tests++; if (mem_read !== er[i]) begin fails++; $display("FAIL lw_mem_read[%0d]: got %b expected %b", i, mem_read, er[i]); end
      if (i == 4) begin
        tests++; if ({mem_to_reg, reg_dst} !== 2'b10) begin fails++; $display("FAIL lw_wb_sel: got %b expected 10", {mem_to_reg, reg_dst}); end
      end
      if (i == 3) begin
        tests++; if (i_or_d !== 1'b1) begin fails++; $display("FAIL lw_i_or_d: got %b expected 1", i_or_d); end
      end
      if (i == 2) begin
        tests++; if ({alu_src_a, alu_src_b} !== 3'b110) begin fails++; $display("FAIL lw_adr_sel: got %b expected 110", {alu_src_a, alu_src_b}); end
      end
    end
  endtask

  // R-type: 0,1,6,7,0 with funct ALU op in 6 and rd write-back in 7.
  task automatic test_rtype();
    logic [3:0] es [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    opcode = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests++; if (state !== es[i]) begin fails++; $display("FAIL r_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      tests++; if (reg_write !== (i == 3)) begin fails++; $display("FAIL r_reg_write[%0d]: got %b", i, reg_write); end
      if (i == 2) begin
        tests++; if (alu_op !== 2'b10) begin fails++; $display("FAIL r_alu_op: got %b expected 10", alu_op); end
      end
      if (i == 3) begin
        tests++; if ({reg_dst, mem_to_reg} !== 2'b10) begin fails++; $display("FAIL r_wb_sel: got %b expected 10", {reg_dst, mem_to_reg}); end
      end
    end
  endtask

  // beq: 0,1,8,0 with conditional PC write from ALUOut.
  task automatic test_beq();
    logic [3:0] es [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
    opcode = 6'b000100; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests++; if (state !== es[i]) begin fails++; $display("FAIL beq_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      if (i == 2) begin
        tests++; if ({pc_write_cond, branch_ne, pc_source, alu_op} !== 6'b100101) begin
          fails++; $display("FAIL beq_outputs: got %b expected 100101", {pc_write_cond, branch_ne, pc_source, alu_op}); end
      end
    end
  endtask

  // addi: 0,1,10,11,0 with immediate operand and rt write-back of ALUOut.
  task automatic test_addi();
    logic [3:0] es [5] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
    opcode = 6'b001000; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests++; if (state !== es[i]) begin fails++; $display("FAIL addi_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      if (i == 2) begin
        tests++; if ({alu_src_a, alu_src_b, alu_op} !== 5'b11000) begin fails++; $display("FAIL addi_ex: got %b expected 11000", {alu_src_a, alu_src_b, alu_op}); end
      end
      if (i == 3) begin
        tests++; if ({reg_write, reg_dst, mem_to_reg} !== 3'b100) begin fails++; $display("FAIL addi_wb: got %b expected 100", {reg_write, reg_dst, mem_to_reg}); end
      end
    end
  endtask

  // Fetch stall: mem_ready low two cycles holds IF, then a jump completes.
  task automatic test_stall_jump();
    logic [3:0] es [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd9, 4'd0};
    opcode = 6'b000010;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = (i >= 2);
      #1;
      tests++; if (state !== es[i]) begin fails++; $display("FAIL stall_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      if (i < 3) begin
        tests++; if (mem_read !== 1'b1) begin fails++; $display("FAIL stall_mem_read[%0d]: got %b expected 1", i, mem_read); end
        tests++; if ({ir_write, pc_write} !== {(i == 2), (i == 2)}) begin fails++; $display("FAIL stall_ir_pc[%0d]: got %b", i, {ir_write, pc_write}); end
      end
      if (i == 4) begin
        tests++; if ({pc_write, pc_source} !== 3'b110) begin fails++; $display("FAIL j_outputs: got %b expected 110", {pc_write, pc_source}); end
      end
    end
  endtask

  // sw stalled in MEM_WR, aborted by reset, then re-run to completion.
  task automatic test_sw_reset();
    logic [3:0] es [10] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    logic       ew [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 6'b101011;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = !(i == 3 || i == 4);
      rst = (i == 4);
      #1;
      tests++; if (state !== es[i]) begin fails++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      tests++; if (mem_write !== ew[i]) begin fails++; $display("FAIL sw_mem_write[%0d]: got %b expected %b", i, mem_write, ew[i]); end
      if (i == 4) begin
        tests++; if ({i_or_d, reg_write, mem_read} !== 3'b000) begin fails++; $display("FAIL sw_reset_outs: got %b expected 000", {i_or_d, reg_write, mem_read}); end
      end
    end
    rst = 1'b0; mem_ready = 1'b1;
  endtask

  // Unsupported opcode: 0,1,0 with a single illegal_op pulse in ID.
  task automatic test_illegal();
    logic [3:0] es [3] = '{4'd0, 4'd1, 4'd0};
    opcode = 6'b111111; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests++; if (state !== es[i]) begin fails++; $display("FAIL ill_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      tests++; if (illegal_op !== (i == 1)) begin fails++; $display("FAIL ill_pulse[%0d]: got %b", i, illegal_op); end
      tests++; if ({reg_write, mem_write} !== 2'b00) begin fails++; $display("FAIL ill_writes[%0d]: got %b expected 00", i, {reg_write, mem_write}); end
    end
  endtask

  // bne opcode: dedicated branch state when enabled, illegal otherwise.
  task automatic test_bne();
`ifdef MULTI_CYCLE_CTRL_BNE_EN
    logic [3:0] es [4] = '{4'd0, 4'd1, 4'd12, 4'd0};
`else
    logic [3:0] es [3] = '{4'd0, 4'd1, 4'd0};
`endif
    opcode = 6'b000101; mem_ready = 1'b1;
    for (int i = 0; i < $size(es); i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests++; if (state !== es[i]) begin fails++; $display("FAIL bne_state[%0d]: got %0d expected %0d", i, state, es[i]); end
`ifdef MULTI_CYCLE_CTRL_BNE_EN
      tests++; if ({branch_ne, pc_write_cond} !== {(i == 2), (i == 2)}) begin fails++; $display("FAIL bne_outs[%0d]: got %b", i, {branch_ne, pc_write_cond}); end
      tests++; if (illegal_op !== 1'b0) begin fails++; $display("FAIL bne_illegal[%0d]: got %b expected 0", i, illegal_op); end
`else
      tests++; if (illegal_op !== (i == 1)) begin fails++; $display("FAIL bne_illegal[%0d]: got %b", i, illegal_op); end
      tests++; if (branch_ne !== 1'b0) begin fails++; $display("FAIL bne_branch_ne[%0d]: got %b expected 0", i, branch_ne); end
`endif
    end
  endtask

  // Sequence all scenarios back to back, each starting in the IF cycle.
  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_addi();
    test_stall_jump();
    test_sw_reset();
    test_illegal();
    test_bne();
    test_lw();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
